pm_rate_pacer: RTL and testbench
================================

# pm_rate_pacer

Runtime-programmable frame pacer that emits one tick per frame slot at a rate of `int + num/den` clock cycles per frame, using a Bresenham-style fractional accumulator so the long-term rate is exact. Ticks use a valid/ready handshake, so a traffic generator can stall without losing rate accounting. Missed slots are counted. It sits in front of the frame generator in the performance-measurement path and replaces the fixed-parameter pulse counter with a block that can be reconfigured without resynthesis.

## Interface
Parameters:
- `PERIOD_WIDTH`, 16: width of the integer period field and cycle counter.
- `FRAC_WIDTH`, 8: width of the fractional numerator, denominator and accumulator.
- `OVR_WIDTH`, 16: width of the overrun counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high; all state is cleared on the `clk` edge where `rst`=1.
- `cfg_period_int`  in  PERIOD_WIDTH  integer cycles per frame; must be ≥ 2.
- `cfg_frac_num`  in  FRAC_WIDTH  fractional numerator; must be < `cfg_frac_den`.
- `cfg_frac_den`  in  FRAC_WIDTH  fractional denominator; must be ≥ 1.
- `cfg_load`  in  1  single-cycle strobe that captures the three `cfg_*` fields.
- `cfg_err`  out  1  one-cycle pulse when a load is rejected.
- `enable`  in  1  level; run while high.
- `tick_valid`  out  1  frame slot due.
- `tick_ready`  in  1  consumer accepts the tick.
- `busy`  out  1  high in the RUN state.
- `overrun_count`  out  OVR_WIDTH  count of slots that became due while a tick was still pending; saturating.

## Operation
- **State machine:** IDLE, RUN, plus DONE when the burst feature is built in.
  - IDLE → RUN when `enable`=1.
  - RUN → IDLE when `enable`=0.
- **Config load:**
  - A load is valid when int ≥ 2, den ≥ 1 and num < den. A valid load writes the shadow registers.
  - An invalid load pulses `cfg_err` and leaves the shadow registers unchanged.
  - The active config is taken from the shadow at RUN entry and at every slot boundary.
  - The accumulator clears whenever a new config becomes active.
- **Slot length L:**
  - At each boundary: `acc_next = acc + num`, computed FRAC_WIDTH+1 bits wide.
  - If `acc_next ≥ den`: L = int+1 and `acc = acc_next − den`. Otherwise: L = int and `acc = acc_next`.
- **Cycle counter:**
  - Counts 0..L−1, then wraps to 0; the wrap is a slot boundary.
  - RUN entry counts as a boundary with the counter at 0.
- **Tick at each boundary:**
  - If no tick is pending, set the pending flag.
  - If a tick is already pending, keep a single pending tick and increment `overrun_count`. The counter saturates at all-ones.
  - The cycle counter never stalls on backpressure, so the rate does not drift.
- **Handshake:**
  - `tick_valid` = pending flag.
  - Pending clears when `tick_valid` and `tick_ready` are both 1.
  - `tick_valid` never deasserts without acceptance, including after a return to IDLE.
  - If acceptance and a new boundary fall on the same cycle, pending stays 1 with no overrun.
- **Reset values:** `tick_valid`=0, `busy`=0, `cfg_err`=0, `overrun_count`=0.
  - Shadow registers reset to int=2, num=0, den=1.
  - Cycle counter and accumulator reset to 0.

## Timing
- `enable` sampled high in IDLE: `busy`=1 and `tick_valid`=1 on the next cycle.
- With `tick_ready` held high, successive `tick_valid` assertions are exactly L cycles apart.
- `cfg_load` takes effect at the first boundary at least one cycle after the load.
- `cfg_err` appears one cycle after `cfg_load`.
- `enable`=0 in RUN: `busy`=0 on the next cycle, the counter stops, and no new boundaries occur.
- `rst` mid-run: every output is at its reset value on the next cycle, and any pending tick is dropped.
- A `cfg_load` on the same cycle as RUN entry is not seen by that entry; the old shadow is used.

## Configuration
- Macro `PM_PACER_BURST_EN`.
- **Defined:**
  - Adds input `burst_len` (16 bits) and output `burst_done` (1 bit).
  - `burst_len` is latched at RUN entry. A value of 0 means continuous running.
  - Accepted ticks are counted. The accepted tick that reaches `burst_len` moves the FSM to DONE; no further boundaries occur.
  - `burst_done` pulses for one cycle on entering DONE.
  - DONE → IDLE when `enable`=0.
- **Undefined:** the ports and the DONE state are absent, and the block always runs continuously.

## Test plan
- Load int=4, num=1, den=3, `tick_ready`=1, then `enable`=1 → tick spacing repeats 4,4,5; exactly 9 ticks in 39 cycles.
- Load int=2, num=0, den=0 → `cfg_err` pulses one cycle later; spacing stays at 2 with the previous config.
- int=3 and `tick_ready` held low for 10 cycles → `tick_valid` stays high, `overrun_count`=3, then one acceptance; next tick lands on the original 3-cycle grid.
- While running at int=5, load int=8 → the change takes effect at the next boundary; following spacings are 8.
- Assert `rst` for one cycle mid-run with a tick pending → next cycle `tick_valid`=0, `busy`=0, `overrun_count`=0.
- With `PM_PACER_BURST_EN`, `burst_len`=4, int=3 → exactly 4 accepted ticks, `burst_done` pulses once, no further ticks while `enable` stays high.

Source files
------------

// File: rtl/pm_rate_pacer.sv
// Fractional-rate frame pacer: one valid/ready tick per slot of int+num/den cycles.
// Optional burst mode (burst_len / burst_done, DONE state) is built with `define PM_PACER_BURST_EN.
module pm_rate_pacer #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH   = 8,
  parameter int unsigned OVR_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PERIOD_WIDTH-1:0] cfg_period_int,
  input  logic [FRAC_WIDTH-1:0]   cfg_frac_num,
  input  logic [FRAC_WIDTH-1:0]   cfg_frac_den,
  input  logic                    cfg_load,
  output logic                    cfg_err,
  input  logic                    enable,
  output logic                    tick_valid,
  input  logic                    tick_ready,
  output logic                    busy,
`ifdef PM_PACER_BURST_EN
  input  logic [15:0]             burst_len,
  output logic                    burst_done,
`endif
  output logic [OVR_WIDTH-1:0]    overrun_count
);

`ifdef PM_PACER_BURST_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] sh_int_q, sh_int_d, act_int_q, act_int_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, last_q, last_d, sel_int;
  logic [FRAC_WIDTH-1:0]   sh_num_q, sh_num_d, sh_den_q, sh_den_d;
  logic [FRAC_WIDTH-1:0]   act_num_q, act_num_d, act_den_q, act_den_d;
  logic [FRAC_WIDTH-1:0]   acc_q, acc_d, sel_num, sel_den, acc_base, acc_wrap;
  logic [FRAC_WIDTH:0]     acc_sum;
  logic [OVR_WIDTH-1:0]    ovr_q, ovr_d;
  logic                    sh_new_q, sh_new_d, pend_q, pend_d, err_q, err_d;
  logic                    enter, accept, boundary, take_sh, carry, cfg_ok, stop_burst;
`ifdef PM_PACER_BURST_EN
  logic [15:0]             blen_q, blen_d, bcnt_q, bcnt_d;
  logic                    bdone_q, bdone_d;
`endif

  always_comb begin
    state_d    = state_q;
    sh_int_d   = sh_int_q;
    sh_num_d   = sh_num_q;
    sh_den_d   = sh_den_q;
    sh_new_d   = sh_new_q;
    act_int_d  = act_int_q;
    act_num_d  = act_num_q;
    act_den_d  = act_den_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    ovr_d      = ovr_q;
    err_d      = 1'b0;
    stop_burst = 1'b0;

    cfg_ok = (cfg_period_int >= PERIOD_WIDTH'(2)) && (cfg_frac_den != '0) &&
             (cfg_frac_num < cfg_frac_den);
    enter  = (state_q == ST_IDLE) && enable;
    accept = pend_q && tick_ready;

`ifdef PM_PACER_BURST_EN
    blen_d  = blen_q;
    bcnt_d  = bcnt_q;
    bdone_d = 1'b0;
    if ((state_q == ST_RUN) && enable && accept) begin
      bcnt_d = bcnt_q + 16'd1;
      if ((blen_q != '0) && (bcnt_q == blen_q - 16'd1))
        stop_burst = 1'b1;
    end
    if (enter) begin
      blen_d = burst_len;
      bcnt_d = '0;
    end
`endif

    boundary = enter || ((state_q == ST_RUN) && enable && (cnt_q == last_q) && !stop_burst);

    // A pending shadow (or RUN entry) restarts the accumulator from zero with the new fraction.
    take_sh  = enter || sh_new_q;
    sel_int  = take_sh ? sh_int_q : act_int_q;
    sel_num  = take_sh ? sh_num_q : act_num_q;
    sel_den  = take_sh ? sh_den_q : act_den_q;
    acc_base = take_sh ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {1'b0, sel_num};
    acc_wrap = acc_sum[FRAC_WIDTH-1:0] - sel_den;
    carry    = (acc_sum >= {1'b0, sel_den});

    if (boundary) begin
      act_int_d = sel_int;
      act_num_d = sel_num;
      act_den_d = sel_den;
      sh_new_d  = 1'b0;
      cnt_d     = '0;
      if (carry) begin
        last_d = sel_int;
        acc_d  = acc_wrap;
      end else begin
        last_d = sel_int - PERIOD_WIDTH'(1);
        acc_d  = acc_sum[FRAC_WIDTH-1:0];
      end
    end else if ((state_q == ST_RUN) && enable) begin
      cnt_d = cnt_q + PERIOD_WIDTH'(1);
    end

    if (cfg_load) begin
      if (cfg_ok) begin
        sh_int_d = cfg_period_int;
        sh_num_d = cfg_frac_num;
        sh_den_d = cfg_frac_den;
        sh_new_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Counter never stalls: a boundary with an unaccepted tick folds into it and counts an overrun.
    pend_d = pend_q && !tick_ready;
    if (boundary) begin
      pend_d = 1'b1;
      if (pend_q && !accept && (ovr_q != '1))
        ovr_d = ovr_q + OVR_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
`ifdef PM_PACER_BURST_EN
        end else if (stop_burst) begin
          state_d = ST_DONE;
          bdone_d = 1'b1;
`endif
        end
      end
`ifdef PM_PACER_BURST_EN
      ST_DONE: if (!enable) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sh_int_q  <= PERIOD_WIDTH'(2);
      sh_num_q  <= '0;
      sh_den_q  <= FRAC_WIDTH'(1);
      sh_new_q  <= 1'b0;
      act_int_q <= PERIOD_WIDTH'(2);
      act_num_q <= '0;
      act_den_q <= FRAC_WIDTH'(1);
      acc_q     <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      ovr_q     <= '0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PM_PACER_BURST_EN
      blen_q    <= '0;
      bcnt_q    <= '0;
      bdone_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_int_q  <= sh_int_d;
      sh_num_q  <= sh_num_d;
      sh_den_q  <= sh_den_d;
      sh_new_q  <= sh_new_d;
      act_int_q <= act_int_d;
      act_num_q <= act_num_d;
      act_den_q <= act_den_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      ovr_q     <= ovr_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
`ifdef PM_PACER_BURST_EN
      blen_q    <= blen_d;
      bcnt_q    <= bcnt_d;
      bdone_q   <= bdone_d;
`endif
    end
  end

  assign tick_valid    = pend_q;
  assign busy          = (state_q == ST_RUN);
  assign cfg_err       = err_q;
  assign overrun_count = ovr_q;
`ifdef PM_PACER_BURST_EN
  assign burst_done    = bdone_q;
`endif

endmodule

// File: tb/tb_pm_rate_pacer.sv
// Scoreboard bench for pm_rate_pacer: expected tick spacings are queued when a run is started
// and compared against accepted-tick gaps; burst checks are built with PM_PACER_BURST_EN.
module tb_pm_rate_pacer;
  localparam int PW = 16;
  localparam int FW = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] cfg_period_int;
  logic [FW-1:0] cfg_frac_num, cfg_frac_den;
  logic          cfg_load, cfg_err, enable, tick_valid, tick_ready, busy;
  logic [OW-1:0] overrun_count;
`ifdef PM_PACER_BURST_EN
  logic [15:0]   burst_len;
  logic          burst_done;
`endif

  always #5 clk = ~clk;

  pm_rate_pacer #(.PERIOD_WIDTH(PW), .FRAC_WIDTH(FW), .OVR_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .cfg_period_int(cfg_period_int), .cfg_frac_num(cfg_frac_num), .cfg_frac_den(cfg_frac_den),
    .cfg_load(cfg_load), .cfg_err(cfg_err), .enable(enable),
    .tick_valid(tick_valid), .tick_ready(tick_ready), .busy(busy),
`ifdef PM_PACER_BURST_EN
    .burst_len(burst_len), .burst_done(burst_done),
`endif
    .overrun_count(overrun_count)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int exp_q[$];
  int epoch  = 0;
  int ntick  = 0;
  int nbdone = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Bresenham slot length from a closed form rather than an accumulator.
  function automatic int slot_len(int pi, int nu, int de, int k);
    return pi + ((k + 1) * nu) / de - (k * nu) / de;
  endfunction

  task automatic monitor();
    int  seen = 0;
    int  prev = 0;
    int  cyc  = 0;
    bit  have = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (epoch != seen) begin
        seen = epoch;
        have = 1'b0;
      end
`ifdef PM_PACER_BURST_EN
      if (burst_done === 1'b1) nbdone++;
`endif
      if (tick_valid === 1'b1 && tick_ready === 1'b1) begin
        ntick++;
        if (have && exp_q.size() > 0) chk("gap", 64'(cyc - prev), 64'(exp_q.pop_front()));
        have = 1'b1;
        prev = cyc;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    epoch++;
  endtask

  task automatic load(input int pi, input int nu, input int de);
    cfg_period_int = PW'(pi);
    cfg_frac_num   = FW'(nu);
    cfg_frac_den   = FW'(de);
    cfg_load       = 1'b1;
    step(1);
    cfg_load       = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  int tab[3][3] = '{'{4, 1, 3}, '{2, 3, 7}, '{6, 5, 6}};
  int bad[3][3] = '{'{2, 0, 0}, '{3, 3, 3}, '{1, 0, 1}};
  int base;

  initial begin
    rst = 1'b1; cfg_period_int = '0; cfg_frac_num = '0; cfg_frac_den = '0;
    cfg_load = 1'b0; enable = 1'b0; tick_ready = 1'b0;
`ifdef PM_PACER_BURST_EN
    burst_len = '0;
`endif
    fork
      monitor();
      begin
        #600000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
      end
    join_none

    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_tick_valid", 64'(tick_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_overrun", 64'(overrun_count), 64'd0);

    // Fractional spacing patterns
    for (int t = 0; t < 3; t++) begin
      do_reset();
      load(tab[t][0], tab[t][1], tab[t][2]);
      tick_ready = 1'b1;
      for (int k = 0; k < 12; k++) exp_q.push_back(slot_len(tab[t][0], tab[t][1], tab[t][2], k));
      base = ntick;
      enable = 1'b1;
      step(1);
      chk("busy_run", 64'(busy), 64'd1);
      if (t == 0) begin
        repeat (38) @(negedge clk);
        #1;
        chk("ticks_in_39", 64'(ntick - base), 64'd9);
      end
      drain("frac_drain", 300);
      enable = 1'b0;
      step(2);
      chk("busy_idle", 64'(busy), 64'd0);
    end

    // Rejected loads keep the reset-default period of 2
    do_reset();
    tick_ready = 1'b1;
    for (int k = 0; k < 12; k++) exp_q.push_back(2);
    enable = 1'b1;
    step(3);
    for (int b = 0; b < 3; b++) begin
      load(bad[b][0], bad[b][1], bad[b][2]);
      chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
      step(1);
      chk("cfg_err_clear", 64'(cfg_err), 64'd0);
    end
    drain("bad_cfg_drain", 100);
    enable = 1'b0;
    step(2);

    // Backpressure: overruns counted, grid preserved
    do_reset();
    load(3, 0, 1);
    tick_ready = 1'b0;
    enable = 1'b1;
    step(1);
    chk("bp_valid_entry", 64'(tick_valid), 64'd1);
    step(10);
    chk("bp_overrun", 64'(overrun_count), 64'd3);
    chk("bp_valid_held", 64'(tick_valid), 64'd1);
    epoch++;
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(3);
    tick_ready = 1'b1;
    step(1);
    chk("bp_accepted", 64'(tick_valid), 64'd0);
    step(1);
    chk("bp_grid_tick", 64'(tick_valid), 64'd1);
    chk("bp_overrun_keep", 64'(overrun_count), 64'd3);
    drain("bp_drain", 100);
    enable = 1'b0;
    step(2);

    // Disable holds a pending tick until accepted, no new boundaries
    do_reset();
    load(3, 0, 1);
    tick_ready = 1'b0;
    enable = 1'b1;
    step(3);
    enable = 1'b0;
    step(1);
    chk("dis_busy", 64'(busy), 64'd0);
    chk("dis_valid_held", 64'(tick_valid), 64'd1);
    step(6);
    chk("dis_valid_still", 64'(tick_valid), 64'd1);
    chk("dis_no_overrun", 64'(overrun_count), 64'd0);
    tick_ready = 1'b1;
    step(1);
    chk("dis_accepted", 64'(tick_valid), 64'd0);
    step(5);
    chk("dis_no_new_tick", 64'(tick_valid), 64'd0);

    // Reconfigure mid-run: 5 -> 8 at the next boundary
    do_reset();
    load(5, 0, 1);
    tick_ready = 1'b1;
    exp_q.push_back(5); exp_q.push_back(5);
    exp_q.push_back(8); exp_q.push_back(8); exp_q.push_back(8);
    enable = 1'b1;
    step(7);
    load(8, 0, 1);
    chk("reload_no_err", 64'(cfg_err), 64'd0);
    drain("reload_drain", 200);
    enable = 1'b0;
    step(2);

    // Reset mid-run with a pending tick and overruns
    do_reset();
    load(3, 0, 1);
    tick_ready = 1'b0;
    enable = 1'b1;
    step(8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mrst_valid", 64'(tick_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_overrun", 64'(overrun_count), 64'd0);
    enable = 1'b0;
    step(2);

`ifdef PM_PACER_BURST_EN
    // Burst of 4 ticks then DONE
    do_reset();
    burst_len = 16'd4;
    load(3, 0, 1);
    tick_ready = 1'b1;
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
    base = ntick;
    begin
      int bd0;
      bd0 = nbdone;
      enable = 1'b1;
      step(30);
      chk("burst_ticks", 64'(ntick - base), 64'd4);
      chk("burst_done_cnt", 64'(nbdone - bd0), 64'd1);
    end
    chk("burst_busy", 64'(busy), 64'd0);
    chk("burst_valid", 64'(tick_valid), 64'd0);
    drain("burst_drain", 5);
    enable = 1'b0;
    step(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
